hdmi_720p_timing_gen: RTL and testbench
=======================================

// Module: hdmi_720p_timing_gen
// PURPOSE
//  Pixel-domain video timing generator for the 1280x720@60 HDMI output path.
//  Produces HS/VS/DE and X/Y counters, and pulls 24-bit RGB from the frame-buffer read FIFO with a ready/valid handshake.
//  Its registered output feeds the TMDS encoder/serialiser, which runs on hdmi_pixel / hdmi_pixel_10x.
//  Flags FIFO underflow so HyperRAM bandwidth problems are visible on led_o/UART.
// PARAMETERS
//  H_ACTIVE 1280 : active pixels per line
//  H_FP     110  : horizontal front porch, in pixels
//  H_SYNC   40   : HS pulse width, in pixels
//  H_BP     220  : horizontal back porch (H_TOTAL = 1650)
//  V_ACTIVE 720  : active lines per frame
//  V_FP     5    : vertical front porch, in lines
//  V_SYNC   5    : VS pulse width, in lines
//  V_BP     20   : vertical back porch (V_TOTAL = 750)
//  HS_POL   1    : 1 = HS active-high
//  VS_POL   1    : 1 = VS active-high
// PORTS
//  pixel_clk_i     in   1   pixel clock, 74.25 MHz nominal; single clock domain
//  rst_i           in   1   asynchronous, active-high reset
//  en_i            in   1   run enable; sampled only at frame boundary
//  pix_data_i      in   24  RGB888 from read FIFO: [23:16]=R, [15:8]=G, [7:0]=B
//  pix_valid_i     in   1   pix_data_i valid
//  pix_rdy_o       out  1   pixel consumed this cycle (FIFO pop)
//  underflow_clr_i in   1   clears underflow_o
//  hs_o            out  1   horizontal sync
//  vs_o            out  1   vertical sync
//  de_o            out  1   data enable
//  rgb_o           out  24  pixel out
//  x_o             out  11  active column of rgb_o
//  y_o             out  10  active row of rgb_o
//  sof_o           out  1   1-cycle pulse with the first active pixel of a frame
//  underflow_o     out  1   sticky underflow flag
// BEHAVIOUR
//  - Reset: h_cnt=v_cnt=0, running=0. hs_o/vs_o held at inactive level (!HS_POL / !VS_POL).
//    de_o, sof_o, pix_rdy_o, underflow_o, rgb_o, x_o, y_o all 0.
//  - Idle (running=0): counters hold 0, outputs stay inactive, pix_rdy_o=0.
//    running<=en_i is evaluated while idle and again at wrap (h=1649, v=749).
//    Deasserting en_i mid-frame therefore completes the frame, then stops at (0,0).
//  - Counting: h_cnt 0..H_TOTAL-1, then wraps to 0 and increments v_cnt. v_cnt wraps at V_TOTAL-1.
//  - Active region is first in each line and frame: act = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
//  - pix_rdy_o = running & act & pix_valid_i (combinational). Exactly one pop per active pixel when the FIFO keeps up.
//  - HS is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//  - VS is active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), over whole lines, aligned to h_cnt=0.
//  - Latency: all outputs are registered, one cycle after the counter state.
//    de_o/hs_o/vs_o/rgb_o/x_o/y_o stay mutually aligned.
//  - rgb_o = pix_data_i when act & pix_valid_i.
//    rgb_o = 24'h000000 when act & !pix_valid_i; underflow_o<=1 in the same cycle.
//    rgb_o = 0 outside the active region.
//  - underflow_o: sticky. Set wins over a simultaneous underflow_clr_i.
//  - sof_o = registered (act && h_cnt==0 && v_cnt==0).
//  - Async reset mid-frame: every output returns to its reset value immediately. No pop is issued until restart.
//  - Widths: h_cnt 11 b, v_cnt 10 b. Parameter sums must fit; no saturation logic.
// CONFIGURATION
//  COLORBAR_EN defined:
//   - adds input pattern_sel_i (1 b);
//   - when pattern_sel_i=1, rgb_o is 8 vertical bars, each H_ACTIVE/8 wide:
//     white, yellow, cyan, green, magenta, red, blue, black;
//   - pix_rdy_o forced 0 and underflow is never set;
//   - pattern_sel_i is sampled at frame boundary only.
//  COLORBAR_EN undefined: no pattern_sel_i port and no bar logic; FIFO path only.
// TESTING
//  T1 reset release, en_i=1, pix_valid_i=1 -> hs_o period 1650 clk, high 40 clk; first hs rise 1391 clk after start.
//  T2 full frame -> vs_o high 5x1650 clk every 1650x750; de_o high 921600 clk; pix_rdy_o count 921600; sof_o once.
//  T3 pix_valid_i=0 at x=100,y=10 -> rgb_o=000000 at that pixel; underflow_o=1 until clr; clr+set same cycle -> stays 1.
//  T4 en_i=0 at v_cnt=300 -> frame completes to v=749; then hs_o/vs_o inactive, de_o=0; en_i=1 restarts at (0,0).
//  T5 rst_i pulse at x=640,y=360 -> outputs at reset values the same cycle; restart yields sof_o on the first active pixel.
//  T6 (COLORBAR_EN) pattern_sel_i=1 -> x=0 FFFFFF, x=160 FFFF00, x=1120 000000; pix_rdy_o=0 all frame.

Source files
------------

// File: rtl/hdmi_720p_timing_gen_if.sv
// Pixel-side bundle of the 720p timing generator: FIFO pop handshake in, video timing and RGB out.
// The pattern_sel_i member exists only when COLORBAR_EN is defined.
interface hdmi_720p_timing_gen_if;
   logic        en_i;
   logic [23:0] pix_data_i;
   logic        pix_valid_i;
   logic        pix_rdy_o;
   logic        underflow_clr_i;
`ifdef COLORBAR_EN
   logic        pattern_sel_i;
`endif
   logic        hs_o;
   logic        vs_o;
   logic        de_o;
   logic [23:0] rgb_o;
   logic [10:0] x_o;
   logic [9:0]  y_o;
   logic        sof_o;
   logic        underflow_o;

   modport master (
`ifdef COLORBAR_EN
      output pattern_sel_i,
`endif
      output en_i, pix_data_i, pix_valid_i, underflow_clr_i,
      input  pix_rdy_o, hs_o, vs_o, de_o, rgb_o, x_o, y_o, sof_o, underflow_o
   );

   modport slave (
`ifdef COLORBAR_EN
      input  pattern_sel_i,
`endif
      input  en_i, pix_data_i, pix_valid_i, underflow_clr_i,
      output pix_rdy_o, hs_o, vs_o, de_o, rgb_o, x_o, y_o, sof_o, underflow_o
   );
endinterface

// File: rtl/hdmi_720p_timing_gen.sv
// 1280x720@60 timing generator; all video outputs registered 1 cycle after the counters, FIFO popped combinationally.
// No backpressure upstream: a missing pixel becomes black and sets sticky underflow. COLORBAR_EN adds an 8-bar test pattern.
module hdmi_720p_timing_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic                   pixel_clk_i,
   input  logic                   rst_i,
   hdmi_720p_timing_gen_if.slave  vid
);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        running;
   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;
   logic        frame_end;
   logic        act;
   logic        hs_act;
   logic        vs_act;
   logic        pop;
   logic        starve;
   logic [23:0] rgb_nxt;

   always_ff @(posedge pixel_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // en_i only matters while idle or on the last pixel of a frame, so frames are never cut short
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = vid.en_i ? RUN : IDLE;
         RUN:     if (frame_end) state_nxt = vid.en_i ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      running = 1'b0;
      if (state == RUN) running = 1'b1;
   end

   always_ff @(posedge pixel_clk_i or posedge rst_i) begin
      if (rst_i) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!running) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 11'd1;
      end
   end

   assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
   assign act       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_act    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   assign vs_act    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

`ifdef COLORBAR_EN
   localparam int BAR_W = H_ACTIVE / 8;

   logic       pattern;
   logic [2:0] bar_idx;

   always_ff @(posedge pixel_clk_i or posedge rst_i) begin
      if (rst_i) begin
         pattern <= 1'b0;
      end else if (!running || frame_end) begin
         pattern <= vid.pattern_sel_i;
      end
   end

   assign bar_idx = 3'(int'(h_cnt) / BAR_W);
   assign pop     = running && act && !pattern && vid.pix_valid_i;
   assign starve  = running && act && !pattern && !vid.pix_valid_i;

   always_comb begin
      rgb_nxt = 24'h000000;
      if (running && act && pattern) begin
         case (bar_idx)
            3'd0:    rgb_nxt = 24'hFFFFFF;
            3'd1:    rgb_nxt = 24'hFFFF00;
            3'd2:    rgb_nxt = 24'h00FFFF;
            3'd3:    rgb_nxt = 24'h00FF00;
            3'd4:    rgb_nxt = 24'hFF00FF;
            3'd5:    rgb_nxt = 24'hFF0000;
            3'd6:    rgb_nxt = 24'h0000FF;
            default: rgb_nxt = 24'h000000;
         endcase
      end else if (pop) begin
         rgb_nxt = vid.pix_data_i;
      end
   end
`else
   assign pop    = running && act && vid.pix_valid_i;
   assign starve = running && act && !vid.pix_valid_i;

   always_comb begin
      rgb_nxt = 24'h000000;
      if (pop) rgb_nxt = vid.pix_data_i;
   end
`endif

   assign vid.pix_rdy_o = pop;

   always_ff @(posedge pixel_clk_i or posedge rst_i) begin
      if (rst_i) begin
         vid.hs_o        <= ~HS_POL;
         vid.vs_o        <= ~VS_POL;
         vid.de_o        <= 1'b0;
         vid.sof_o       <= 1'b0;
         vid.rgb_o       <= '0;
         vid.x_o         <= '0;
         vid.y_o         <= '0;
         vid.underflow_o <= 1'b0;
      end else begin
         vid.hs_o  <= (running && hs_act) ? HS_POL : ~HS_POL;
         vid.vs_o  <= (running && vs_act) ? VS_POL : ~VS_POL;
         vid.de_o  <= running && act;
         vid.sof_o <= running && act && (h_cnt == '0) && (v_cnt == '0);
         vid.rgb_o <= rgb_nxt;
         vid.x_o   <= (running && act) ? h_cnt : '0;
         vid.y_o   <= (running && act) ? v_cnt : '0;
         // a starved pixel in the same cycle as a clear still leaves the flag set
         if (starve) begin
            vid.underflow_o <= 1'b1;
         end else if (vid.underflow_clr_i) begin
            vid.underflow_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_hdmi_720p_timing_gen.sv
// Scoreboard bench for hdmi_720p_timing_gen on a shrunken raster (28x9 total, 16x4 active).
// A FIFO model feeds pixels; expected pixels are queued at fill time and checked whenever de_o is high.
module tb_hdmi_720p_timing_gen;
   localparam int HA = 16, HF = 3, HSW = 4, HB = 5;
   localparam int VA = 4,  VF = 1, VSW = 2, VB = 2;
   localparam int HT = HA + HF + HSW + HB;
   localparam int VT = VA + VF + VSW + VB;
   localparam int FRAME = HT * VT;

   typedef struct packed {
      logic [23:0] dat;
      logic        hole;
      logic        clr;
   } fifo_ent_t;

   typedef struct packed {
      logic [23:0] rgb;
      logic [10:0] x;
      logic [9:0]  y;
      logic        sof;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic hole_clr = 1'b0;
   logic clr_req = 1'b0;
   logic drv_rdy = 1'b0;
   logic drv_hole = 1'b0;
   logic hs_p = 1'b0, vs_p = 1'b0, de_p = 1'b0;

   fifo_ent_t fifo[$];
   exp_t      expq[$];
   exp_t      mon_e;
   int        de_rise[$], hs_rise[$], hs_fall[$], vs_rise[$], vs_fall[$], sof_at[$];
   int        errors = 0, checks = 0;
   int        cyc = 0, de_cnt = 0, rdy_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   hdmi_720p_timing_gen_if vid();
   assign vid.underflow_clr_i = hole_clr | clr_req;
`ifdef COLORBAR_EN
   assign vid.pattern_sel_i = 1'b0;
`endif

   hdmi_720p_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut (
      .pixel_clk_i(clk),
      .rst_i(rst),
      .vid(vid)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // One frame of raster-ordered pixels; (hx,hy) becomes a FIFO gap, optionally with a clear in that cycle.
   task automatic fill_frame(input int f, input int hx, input int hy, input logic hclr);
      for (int y = 0; y < VA; y++) begin
         for (int x = 0; x < HA; x++) begin
            logic        h;
            logic [23:0] d;
            h = (x == hx) && (y == hy);
            d = {8'(f + 'h40), 8'(y), 8'(x)};
            fifo.push_back('{dat: d, hole: h, clr: h & hclr});
            expq.push_back('{rgb: h ? 24'h000000 : d, x: 11'(x), y: 10'(y), sof: (x == 0) && (y == 0)});
         end
      end
   endtask

   task automatic wait_sof(input int n);
      int k;
      k = 0;
      while (sof_at.size() < n && k < 3 * FRAME) begin
         @(posedge clk);
         #2;
         k++;
      end
      if (sof_at.size() < n) begin
         checks++;
         errors++;
         $display("FAIL sof_wait: saw %0d sof pulses, required %0d", sof_at.size(), n);
      end
   endtask

   // FIFO model: pop when the DUT took the head last cycle; a gap entry is dropped after one cycle.
   initial begin
      vid.pix_valid_i = 1'b0;
      vid.pix_data_i  = 24'h0;
      forever begin
         @(posedge clk);
         if (!rst && fifo.size() > 0 && (drv_rdy || drv_hole)) fifo.delete(0);
         #1;
         drv_hole = (fifo.size() > 0) && fifo[0].hole;
         hole_clr = drv_hole && fifo[0].clr;
         vid.pix_valid_i = (fifo.size() > 0) && !fifo[0].hole;
         vid.pix_data_i  = (fifo.size() > 0) ? fifo[0].dat : 24'h0;
         #2;
         drv_rdy = vid.pix_rdy_o;
      end
   end

   always @(negedge clk) begin
      if (vid.sof_o) sof_at.push_back(cyc);
      if (vid.pix_rdy_o) rdy_cnt++;
      if (vid.de_o) begin
         de_cnt++;
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_de: de_o=1 at x=%0d y=%0d, no pixel expected", vid.x_o, vid.y_o);
         end else begin
            mon_e = expq.pop_front();
            chk($sformatf("rgb(%0d,%0d)", mon_e.x, mon_e.y), 64'(vid.rgb_o), 64'(mon_e.rgb));
            chk($sformatf("xy(%0d,%0d)", mon_e.x, mon_e.y), 64'({vid.x_o, vid.y_o}), 64'({mon_e.x, mon_e.y}));
            chk($sformatf("sof(%0d,%0d)", mon_e.x, mon_e.y), 64'(vid.sof_o), 64'(mon_e.sof));
         end
      end
      if (vid.de_o && !de_p) de_rise.push_back(cyc);
      if (vid.hs_o && !hs_p) hs_rise.push_back(cyc);
      if (!vid.hs_o && hs_p) hs_fall.push_back(cyc);
      if (vid.vs_o && !vs_p) vs_rise.push_back(cyc);
      if (!vid.vs_o && vs_p) vs_fall.push_back(cyc);
      de_p = vid.de_o;
      hs_p = vid.hs_o;
      vs_p = vid.vs_o;
   end

   initial begin
      rst = 1'b0;
      vid.en_i = 1'b0;
      fill_frame(0, 5, 2, 1'b0);
      fill_frame(1, 3, 1, 1'b1);
      fill_frame(2, -1, -1, 1'b0);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_hs", 64'(vid.hs_o), 64'(0));
      chk("rst_vs", 64'(vid.vs_o), 64'(0));
      chk("rst_de", 64'(vid.de_o), 64'(0));
      chk("rst_sof", 64'(vid.sof_o), 64'(0));
      chk("rst_uf", 64'(vid.underflow_o), 64'(0));
      chk("rst_rgb_xy", 64'({vid.rgb_o, vid.x_o, vid.y_o}), 64'(0));
      chk("rst_rdy_with_valid", 64'({vid.pix_valid_i, vid.pix_rdy_o}), 64'(2'b10));

      // Start with data always available except the planted gap at (5,2)
      @(posedge clk);
      #1 rst = 1'b0;
      vid.en_i = 1'b1;
      wait_sof(2);
      chk("hs_first_rise_after_de", 64'(hs_rise[0] - de_rise[0]), 64'(HA + HF));
      chk("hs_period", 64'(hs_rise[1] - hs_rise[0]), 64'(HT));
      chk("hs_width", 64'(hs_fall[0] - hs_rise[0]), 64'(HSW));
      chk("vs_rise_after_sof", 64'(vs_rise[0] - sof_at[0]), 64'((VA + VF) * HT));
      chk("vs_width", 64'(vs_fall[0] - vs_rise[0]), 64'(VSW * HT));
      chk("frame_period", 64'(sof_at[1] - sof_at[0]), 64'(FRAME));
      chk("uf_set", 64'(vid.underflow_o), 64'(1));

      @(posedge clk);
      #1 clr_req = 1'b1;
      @(posedge clk);
      #1 clr_req = 1'b0;
      @(negedge clk);
      chk("uf_cleared", 64'(vid.underflow_o), 64'(0));

      // Frame 1 gap at (3,1) arrives together with a clear
      wait_sof(3);
      chk("uf_set_beats_clr", 64'(vid.underflow_o), 64'(1));

      // Drop enable around line 2 of frame 2: the frame must still complete, then stop
      repeat (60) @(posedge clk);
      vid.en_i = 1'b0;
      repeat (2 * FRAME) @(posedge clk);
      #2;
      chk("en_off_frame_done", 64'(expq.size()), 64'(0));
      chk("en_off_no_restart", 64'(sof_at.size()), 64'(3));
      chk("de_total_3frames", 64'(de_cnt), 64'(3 * HA * VA));
      chk("pop_total_3frames", 64'(rdy_cnt), 64'(3 * HA * VA - 2));
      fill_frame(3, -1, -1, 1'b0);
      repeat (HT) @(posedge clk);
      @(negedge clk);
      chk("idle_outputs", 64'({vid.hs_o, vid.vs_o, vid.de_o}), 64'(0));
      chk("idle_rdy_with_valid", 64'({vid.pix_valid_i, vid.pix_rdy_o}), 64'(2'b10));

      // Restart from idle, then reset in the middle of the frame at counter (8,2)
      vid.en_i = 1'b1;
      wait_sof(4);
      repeat (62) @(posedge clk);
      #2;
      chk("mid_de", 64'(vid.de_o), 64'(1));
      chk("mid_xy", 64'({vid.x_o, vid.y_o}), 64'({11'd7, 10'd2}));
      rst = 1'b1;
      fifo.delete();
      expq.delete();
      #1;
      chk("async_rst_de_sof", 64'({vid.de_o, vid.sof_o}), 64'(0));
      chk("async_rst_hs_vs", 64'({vid.hs_o, vid.vs_o}), 64'(0));
      chk("async_rst_rgb_xy", 64'({vid.rgb_o, vid.x_o, vid.y_o}), 64'(0));
      chk("async_rst_uf", 64'(vid.underflow_o), 64'(0));
      chk("async_rst_rdy", 64'(vid.pix_rdy_o), 64'(0));

      fill_frame(4, -1, -1, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_sof(5);
      vid.en_i = 1'b0;
      repeat (FRAME + HT) @(posedge clk);
      #2;
      chk("restart_frame_done", 64'(expq.size()), 64'(0));
      chk("de_total_end", 64'(de_cnt), 64'(3 * HA * VA + 39 + HA * VA));
      chk("pop_total_end", 64'(rdy_cnt), 64'(3 * HA * VA - 2 + 40 + HA * VA));
      chk("sof_total_end", 64'(sof_at.size()), 64'(5));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
